pulse_pacer: RTL
================

# pulse_pacer

Source-side pulse pacer for the toggle-based single-bit pulse synchronizer. It accepts single-cycle request pulses at any rate and counts pending requests. It then re-emits them as single-cycle pulses spaced at least GAP cycles apart, so no pulse is lost when the synchronizer's input toggle moves faster than the destination domain can sample it. It sits in the source clock domain, directly in front of the synchronizer's pulse input.

## Interface
- GAP, 4: cycles from one pulse_out to the next; legal range 2..255.
- CNT_W, 4: pending-counter width; saturates at 2^CNT_W-1.
- clk_in  input  1  single clock.
- rst_in  input  1  synchronous, active-high reset.
- pulse_in  input  1  request pulse; every high cycle is one request.
- pulse_out  output  1  paced single-cycle pulse, registered.
- busy  output  1  high while requests are pending or gap_cnt != 0.
- pending  output  CNT_W  pending request count (present only with PULSE_PACER_STATUS_EN).
- ovf  output  1  sticky drop flag (present only with PULSE_PACER_STATUS_EN).
- ovf_clr  input  1  clears ovf (present only with PULSE_PACER_STATUS_EN).

## Operation
- Internal registers: pending counter (CNT_W bits), gap_cnt (8 bits), pulse_out register.
- Two implicit states:
  - READY when gap_cnt == 0.
  - SPACING when gap_cnt != 0.
- The block fires in READY when (pending != 0 or pulse_in). Requests are served in arrival order.
- On fire:
  - pulse_out <= 1.
  - gap_cnt <= GAP-1.
  - pending <= pending + pulse_in - 1.
- When not firing:
  - pulse_out <= 0.
  - gap_cnt decrements if nonzero.
  - pending increments if pulse_in is high and pending < max.
- Saturation: pulse_in high while pending == max and no fire that cycle means the request is dropped and ovf is set.
  - pulse_in with a simultaneous fire at pending == max is a net change of zero and is not a drop.
- Arithmetic: the pending counter never wraps in either direction. gap_cnt never underflows.
- busy = (pending != 0) | (gap_cnt != 0), decoded from registers.
- Reset, including mid-operation:
  - Clears pulse_out, pending, gap_cnt and ovf.
  - Pending requests are discarded.
  - pulse_in is ignored during reset cycles.

## Timing
- Reset values: pulse_out = 0, busy = 0, pending = 0, ovf = 0.
- Latency from an idle block: pulse_in sampled high in cycle N gives pulse_out high in cycle N+1. pending stays 0.
- Spacing: consecutive pulse_out highs occur exactly GAP cycles apart while requests remain.
- pulse_out is never high in two adjacent cycles.
- busy falls GAP-1 cycles after the last pulse_out, provided pending == 0.
- ovf sets in the cycle after the dropping pulse_in.
- ovf_clr clears ovf one cycle later. If a drop and ovf_clr occur in the same cycle, the set wins.

## Configuration
- PULSE_PACER_STATUS_EN:
  - Defined: the pending, ovf and ovf_clr ports exist and ovf tracks drops as above.
  - Undefined: those ports and the ovf register are removed, and drops are silent.
  - pulse_out and busy behaviour are identical in both builds.

## Test plan
- Reset: hold rst_in high for 3 cycles with pulse_in = 1. Required: pulse_out = 0, busy = 0, pending = 0, ovf = 0 throughout, and no pulse_out in the cycle after release.
- Single request (GAP = 4): pulse_in high in cycle 10. Required: pulse_out high only in cycle 11, busy high in cycles 11–13, low from cycle 14.
- Burst (GAP = 4, CNT_W = 4): pulse_in high in cycles 10–14. Required: pulse_out in cycles 11, 15, 19, 23, 27, then busy low from cycle 30.
- Overflow (GAP = 4, CNT_W = 2): pulse_in high in cycles 10–17. Required:
  - pending = 3 after cycle 13.
  - Pulses in cycles 15–17 are dropped.
  - ovf = 1 from cycle 16.
  - pulse_out in cycles 11, 15, 19, 23, 27 only.
  - ovf_clr pulsed in cycle 30 gives ovf = 0 in cycle 31.
- Mid-operation reset: with pending = 3 and gap_cnt = 2, pulse rst_in for one cycle. Required: pending = 0, busy = 0 and no further pulse_out. A new pulse_in afterwards gives pulse_out one cycle later.
- Clear/drop collision: pulse_in while pending == max and no fire, in the same cycle as ovf_clr. Required: ovf remains 1.

Source files
------------

// File: rtl/pulse_pacer.sv
// pulse_pacer: source-side pacer in front of a toggle pulse synchronizer.
// Accepts request pulses at any rate, counts the ones not yet served and
// re-emits them as single-cycle pulses spaced GAP cycles apart.
//
// Optional build macro: PULSE_PACER_STATUS_EN
//   defined   -> pending/ovf/ovf_clr ports exist; ovf is a sticky drop flag
//   undefined -> those ports and the ovf register are absent; drops are silent
//
// Implicit states (no separate state register; decoded from gap_cnt):
//   state   | meaning
//   READY   | gap_cnt == 0, a pulse may be emitted this cycle
//   SPACING | gap_cnt != 0, holding off until the gap has elapsed

module pulse_pacer #(
    parameter int GAP   = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             pulse_in,
`ifdef PULSE_PACER_STATUS_EN
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] pending,
    output logic             ovf,
`endif
    output logic             pulse_out,
    output logic             busy
);

    localparam logic [7:0]       GAP_RELOAD = 8'(GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic [CNT_W-1:0] pend_q;
    logic [CNT_W-1:0] pend_nxt;
    logic [7:0]       gap_cnt;
    logic [7:0]       gap_nxt;
    logic             pulse_q;
    logic             pulse_nxt;
    logic             ready;
    logic             fire;
    logic             at_max;

`ifdef PULSE_PACER_STATUS_EN
    logic             ovf_q;
    logic             ovf_nxt;
    logic             drop;
`endif

    assign ready  = (gap_cnt == 8'd0);
    assign fire   = ready & ((pend_q != '0) | pulse_in);
    assign at_max = (pend_q == CNT_MAX);

    // State register: pending counter, gap timer and the registered pulse.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pend_q  <= '0;
            gap_cnt <= 8'd0;
            pulse_q <= 1'b0;
        end else begin
            pend_q  <= pend_nxt;
            gap_cnt <= gap_nxt;
            pulse_q <= pulse_nxt;
        end
    end

    // Next-state decode: fire reloads the gap timer and consumes one request;
    // otherwise the timer runs down and new requests accumulate up to max.
    always_comb begin
        pend_nxt  = pend_q;
        gap_nxt   = gap_cnt;
        pulse_nxt = 1'b0;
        if (fire) begin
            pulse_nxt = 1'b1;
            gap_nxt   = GAP_RELOAD;
            // A request arriving in the firing cycle replaces the one served,
            // so the count is unchanged; fire with pend_q == 0 implies pulse_in.
            if (!pulse_in) begin
                pend_nxt = pend_q - CNT_ONE;
            end
        end else begin
            if (gap_cnt != 8'd0) begin
                gap_nxt = gap_cnt - 8'd1;
            end
            if (pulse_in && !at_max) begin
                pend_nxt = pend_q + CNT_ONE;
            end
        end
    end

`ifdef PULSE_PACER_STATUS_EN
    assign drop = pulse_in & ~fire & at_max;

    // Sticky overflow flag: a drop in the same cycle as ovf_clr keeps it set.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_nxt;
        end
    end

    // Overflow next-state: set has priority over clear.
    always_comb begin
        ovf_nxt = ovf_q;
        if (drop) begin
            ovf_nxt = 1'b1;
        end else if (ovf_clr) begin
            ovf_nxt = 1'b0;
        end
    end
`endif

    // Output decode, purely from registers.
    always_comb begin
        pulse_out = pulse_q;
        busy      = (pend_q != '0) | (gap_cnt != 8'd0);
`ifdef PULSE_PACER_STATUS_EN
        pending   = pend_q;
        ovf       = ovf_q;
`endif
    end

endmodule
